// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: forwarding selects, load-use stall and taken-branch
// flush control for the 5-stage MIPS pipeline.
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating stall and flush
// counters. Without it, o_stall_cnt and o_flush_cnt are tied to zero.
// Handshake note: there is no valid/ready traffic here. o_pc_write and
// o_ifid_write are level enables, and the flush outputs are level zeroing
// requests. All of them apply to the same cycle in which they are driven.
module hazard_forward_unit #(
    parameter int LOAD_STALL_CYCLES = 1,   // legal range 1..7
    parameter int CNT_W             = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_ifid_rs,
    input  logic [4:0]       i_ifid_rt,
    input  logic [4:0]       i_idex_rs,
    input  logic [4:0]       i_idex_rt,
    input  logic             i_idex_memread,
    input  logic [4:0]       i_exmem_rd,
    input  logic             i_exmem_regwrite,
    input  logic [4:0]       i_memwb_rd,
    input  logic             i_memwb_regwrite,
    input  logic             i_branch_taken,
    output logic [1:0]       FA,
    output logic [1:0]       FB,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_if_flush,
    output logic             o_id_flush,
    output logic             ex_flush,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    // Stall length minus the detect cycle, which is spent in RUN.
    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

    logic [0:0] state_q, state_d;
    logic [2:0] scnt_q, scnt_d;
    logic       ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b;
    logic       hz;

    // Match checks for each producer stage. $0 is never a forwarding source.
    assign ex_hit_a = i_exmem_regwrite && (i_exmem_rd != 5'd0) && (i_exmem_rd == i_idex_rs);
    assign ex_hit_b = i_exmem_regwrite && (i_exmem_rd != 5'd0) && (i_exmem_rd == i_idex_rt);
    assign wb_hit_a = i_memwb_regwrite && (i_memwb_rd != 5'd0) && (i_memwb_rd == i_idex_rs);
    assign wb_hit_b = i_memwb_regwrite && (i_memwb_rd != 5'd0) && (i_memwb_rd == i_idex_rt);

    // A load in ID/EX writes a register that the instruction in IF/ID reads.
    assign hz = i_idex_memread && (i_idex_rt != 5'd0) &&
                ((i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt));

    // Forwarding selects. EX/MEM holds the newer value, so it wins.
    // Code 11 is never produced.
    always_comb begin
        FA = 2'b00;
        FB = 2'b00;
        if (!i_rst) begin
            if (ex_hit_a)      FA = 2'b10;
            else if (wb_hit_a) FA = 2'b01;
            if (ex_hit_b)      FB = 2'b10;
            else if (wb_hit_b) FB = 2'b01;
        end
    end

    // Stall/flush arbitration. A taken branch outranks both a stall in
    // progress and a fresh hazard.
    always_comb begin
        state_d      = state_q;
        scnt_d       = scnt_q;
        o_pc_write   = 1'b1;
        o_ifid_write = 1'b1;
        o_if_flush   = 1'b0;
        o_id_flush   = 1'b0;
        ex_flush     = 1'b0;
        if (i_branch_taken) begin
            o_if_flush = 1'b1;
            o_id_flush = 1'b1;
            ex_flush   = 1'b1;
            state_d    = ST_RUN;
            scnt_d     = 3'd0;
        end else if (state_q == ST_STALL) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_id_flush   = 1'b1;
            if (scnt_q == 3'd1) begin
                state_d = ST_RUN;
                scnt_d  = 3'd0;
            end else begin
                scnt_d = scnt_q - 3'd1;
            end
        end else if (hz) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_id_flush   = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_d = ST_STALL;
                scnt_d  = STALL_RELOAD;
            end
        end
        // Reset holds the pipeline in the idle pattern.
        if (i_rst) begin
            o_pc_write   = 1'b1;
            o_ifid_write = 1'b1;
            o_if_flush   = 1'b0;
            o_id_flush   = 1'b0;
            ex_flush     = 1'b0;
        end
    end

    // State register and stall down-counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_RUN;
            scnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating performance counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!o_pc_write && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (i_branch_taken && !(&flush_cnt_q))
                flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: two instances share one set of inputs.
// u1 has a 1-cycle load stall and 2-bit counters, so saturation can be reached.
// u3 has a 3-cycle load stall and 16-bit counters.
module tb_hazard_forward_unit;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  logic [4:0] i_ifid_rs, i_ifid_rt, i_idex_rs, i_idex_rt, i_exmem_rd, i_memwb_rd;
  logic       i_idex_memread, i_exmem_regwrite, i_memwb_regwrite, i_branch_taken;

  logic [1:0]  u1_fa, u1_fb, u3_fa, u3_fb;
  logic        u1_pc, u1_ifid, u1_iff, u1_idf, u1_exf;
  logic        u3_pc, u3_ifid, u3_iff, u3_idf, u3_exf;
  logic [1:0]  u1_scnt, u1_fcnt;
  logic [15:0] u3_scnt, u3_fcnt;

  hazard_forward_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(2)) u1 (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ifid_rs(i_ifid_rs), .i_ifid_rt(i_ifid_rt),
    .i_idex_rs(i_idex_rs), .i_idex_rt(i_idex_rt), .i_idex_memread(i_idex_memread),
    .i_exmem_rd(i_exmem_rd), .i_exmem_regwrite(i_exmem_regwrite),
    .i_memwb_rd(i_memwb_rd), .i_memwb_regwrite(i_memwb_regwrite),
    .i_branch_taken(i_branch_taken),
    .FA(u1_fa), .FB(u1_fb), .o_pc_write(u1_pc), .o_ifid_write(u1_ifid),
    .o_if_flush(u1_iff), .o_id_flush(u1_idf), .ex_flush(u1_exf),
    .o_stall_cnt(u1_scnt), .o_flush_cnt(u1_fcnt)
  );

  hazard_forward_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u3 (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ifid_rs(i_ifid_rs), .i_ifid_rt(i_ifid_rt),
    .i_idex_rs(i_idex_rs), .i_idex_rt(i_idex_rt), .i_idex_memread(i_idex_memread),
    .i_exmem_rd(i_exmem_rd), .i_exmem_regwrite(i_exmem_regwrite),
    .i_memwb_rd(i_memwb_rd), .i_memwb_regwrite(i_memwb_regwrite),
    .i_branch_taken(i_branch_taken),
    .FA(u3_fa), .FB(u3_fb), .o_pc_write(u3_pc), .o_ifid_write(u3_ifid),
    .o_if_flush(u3_iff), .o_id_flush(u3_idf), .ex_flush(u3_exf),
    .o_stall_cnt(u3_scnt), .o_flush_cnt(u3_fcnt)
  );

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Expected output vector: {FA, FB, pc_write, ifid_write, if_flush, id_flush, ex_flush}.
  localparam logic [8:0] IDLE  = 9'b00_00_1_1_0_0_0;
  localparam logic [8:0] STALL = 9'b00_00_0_0_0_1_0;
  localparam logic [8:0] FLUSH = 9'b00_00_1_1_1_1_1;

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q1[$];
  logic [8:0] exp_q3[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference forwarding rule for one EX source operand.
  function automatic logic [1:0] fwd_ref(input logic [4:0] src, input logic [4:0] exrd,
                                         input logic exrw, input logic [4:0] wbrd,
                                         input logic wbrw);
    if (exrw && exrd != 0 && exrd == src) return 2'b10;
    if (wbrw && wbrd != 0 && wbrd == src) return 2'b01;
    return 2'b00;
  endfunction

  // ---------------- driver tasks ----------------
  // Push the expected vectors, compare at the negedge, then advance past the posedge.
  task automatic step(input string tag, input logic [8:0] e1, input logic [8:0] e3);
    logic [8:0] x1, x3;
    exp_q1.push_back(e1);
    exp_q3.push_back(e3);
    @(negedge i_clk);
    x1 = exp_q1.pop_front();
    x3 = exp_q3.pop_front();
    check({tag, "_u1"}, {23'd0, u1_fa, u1_fb, u1_pc, u1_ifid, u1_iff, u1_idf, u1_exf}, {23'd0, x1});
    check({tag, "_u3"}, {23'd0, u3_fa, u3_fb, u3_pc, u3_ifid, u3_iff, u3_idf, u3_exf}, {23'd0, x3});
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_ifid_rs = 0; i_ifid_rt = 0; i_idex_rs = 0; i_idex_rt = 0;
    i_exmem_rd = 0; i_memwb_rd = 0;
    i_idex_memread = 0; i_exmem_regwrite = 0; i_memwb_regwrite = 0; i_branch_taken = 0;
  endtask

  task automatic check_cnt(input string tag, input int s1, input int f1, input int s3, input int f3);
    check({tag, "_scnt_u1"}, {30'd0, u1_scnt}, PERF ? s1 : 0);
    check({tag, "_fcnt_u1"}, {30'd0, u1_fcnt}, PERF ? f1 : 0);
    check({tag, "_scnt_u3"}, {16'd0, u3_scnt}, PERF ? s3 : 0);
    check({tag, "_fcnt_u3"}, {16'd0, u3_fcnt}, PERF ? f3 : 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [8:0] ev;
    clear_inputs();
    // Reset: forwarding inputs match, yet the outputs stay idle.
    i_rst = 1;
    i_exmem_rd = 5; i_exmem_regwrite = 1; i_idex_rs = 5; i_idex_rt = 5;
    step("rst", IDLE, IDLE);
    i_rst = 0;
    check_cnt("after_rst", 0, 0, 0, 0);

    // EX/MEM has priority over MEM/WB.
    i_memwb_rd = 5; i_memwb_regwrite = 1;
    step("fwd_ex", 9'b10_10_1_1_0_0_0, 9'b10_10_1_1_0_0_0);
    i_exmem_regwrite = 0;
    step("fwd_wb", 9'b01_01_1_1_0_0_0, 9'b01_01_1_1_0_0_0);

    // $0 is never forwarded, and a producer without regwrite is ignored.
    clear_inputs();
    i_exmem_rd = 0; i_exmem_regwrite = 1; i_memwb_rd = 0; i_memwb_regwrite = 1;
    step("zero_reg", IDLE, IDLE);
    clear_inputs();
    i_exmem_rd = 7; i_exmem_regwrite = 0; i_idex_rs = 7;
    step("no_rw", IDLE, IDLE);

    // Random forwarding patterns over a small register range to get many matches.
    for (int i = 0; i < 24; i++) begin
      clear_inputs();
      i_idex_rs = 5'($urandom_range(0, 3));
      i_idex_rt = 5'($urandom_range(0, 3));
      i_exmem_rd = 5'($urandom_range(0, 3));
      i_memwb_rd = 5'($urandom_range(0, 3));
      i_exmem_regwrite = 1'($urandom_range(0, 1));
      i_memwb_regwrite = 1'($urandom_range(0, 1));
      ev = {fwd_ref(i_idex_rs, i_exmem_rd, i_exmem_regwrite, i_memwb_rd, i_memwb_regwrite),
            fwd_ref(i_idex_rt, i_exmem_rd, i_exmem_regwrite, i_memwb_rd, i_memwb_regwrite),
            5'b1_1_0_0_0};
      step("fwd_rand", ev, ev);
    end

    // A load targeting $0 is not a hazard.
    clear_inputs();
    i_idex_memread = 1;
    step("load_r0", IDLE, IDLE);

    // Load-use on rs: one bubble for u1, three for u3.
    clear_inputs();
    i_idex_memread = 1; i_idex_rt = 8; i_ifid_rs = 8;
    step("lu_rs0", STALL, STALL);
    clear_inputs();
    step("lu_rs1", IDLE, STALL);
    step("lu_rs2", IDLE, STALL);
    step("lu_rs3", IDLE, IDLE);
    check_cnt("lu_rs", 1, 0, 3, 0);

    // Load-use on rt.
    i_idex_memread = 1; i_idex_rt = 8; i_ifid_rt = 8;
    step("lu_rt0", STALL, STALL);
    clear_inputs();
    step("lu_rt1", IDLE, STALL);
    step("lu_rt2", IDLE, STALL);
    step("lu_rt3", IDLE, IDLE);
    check_cnt("lu_rt", 2, 0, 6, 0);

    // A taken branch in the second stall cycle aborts the stall.
    i_idex_memread = 1; i_idex_rt = 9; i_ifid_rs = 9;
    step("br_st0", STALL, STALL);
    clear_inputs();
    i_branch_taken = 1;
    step("br_st1", FLUSH, FLUSH);
    i_branch_taken = 0;
    step("br_st2", IDLE, IDLE);
    check_cnt("br_stall", 3, 1, 7, 1);

    // A taken branch overrides a fresh hazard in RUN.
    i_idex_memread = 1; i_idex_rt = 9; i_ifid_rs = 9; i_branch_taken = 1;
    step("br_hz0", FLUSH, FLUSH);
    clear_inputs();
    step("br_hz1", IDLE, IDLE);

    // u1 stall counter saturates at 3.
    i_idex_memread = 1; i_idex_rt = 10; i_ifid_rt = 10;
    step("sat0", STALL, STALL);
    clear_inputs();
    step("sat1", IDLE, STALL);
    step("sat2", IDLE, STALL);
    step("sat3", IDLE, IDLE);
    check_cnt("sat", 3, 2, 10, 2);

    // Reset in the middle of a stall abandons it.
    i_idex_memread = 1; i_idex_rt = 11; i_ifid_rs = 11;
    step("rst_st0", STALL, STALL);
    clear_inputs();
    i_rst = 1;
    step("rst_st1", IDLE, IDLE);
    i_rst = 0;
    step("rst_st2", IDLE, IDLE);
    check_cnt("rst_mid", 0, 0, 0, 0);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog: the run always ends by itself.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Pipeline hazard controller for the 5-stage MIPS core.
- Generates the FA/FB forwarding selects and the ex_flush signal that the EX stage consumes.
- Detects load-use hazards and stalls PC and IF/ID while injecting bubbles into ID/EX.
- Flushes younger stages when a branch is taken in MEM.
- A small state machine holds multi-cycle load stalls and arbitrates stall against flush.

Parameters:
LOAD_STALL_CYCLES, 1, bubble cycles inserted per load-use hazard (legal range 1..7)
CNT_W, 16, width of the optional performance counters

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, synchronous, active-high
i_ifid_rs  input  5  rs field of the instruction in IF/ID
i_ifid_rt  input  5  rt field of the instruction in IF/ID
i_idex_rs  input  5  rs of the instruction in ID/EX (EX source A)
i_idex_rt  input  5  rt of the instruction in ID/EX (EX source B / load target)
i_idex_memread  input  1  instruction in ID/EX is a load
i_exmem_rd  input  5  write register held in EX/MEM
i_exmem_regwrite  input  1  RegWrite held in EX/MEM
i_memwb_rd  input  5  write register held in MEM/WB
i_memwb_regwrite  input  1  RegWrite held in MEM/WB
i_branch_taken  input  1  branch in MEM resolved taken (EX/MEM Branch & zero)
FA  output  2  EX source-A select: 00 regfile, 01 WB_D, 10 MEM_D
FB  output  2  EX source-B select, same encoding
o_pc_write  output  1  PC update enable
o_ifid_write  output  1  IF/ID load enable
o_if_flush  output  1  zero the IF/ID register
o_id_flush  output  1  zero the control fields entering ID/EX (bubble)
ex_flush  output  1  zero the WB/MEM control entering EX/MEM
o_stall_cnt  output  CNT_W  stall cycles counted (optional feature only)
o_flush_cnt  output  CNT_W  taken-branch flushes counted (optional feature only)

Interface decision: one clock, i_clk; reset i_rst is synchronous and active-high.

Behaviour:
Forwarding (combinational from pipeline-register inputs):
- FA = 10 when i_exmem_regwrite, i_exmem_rd != 0 and i_exmem_rd == i_idex_rs.
- Otherwise FA = 01 when i_memwb_regwrite, i_memwb_rd != 0 and i_memwb_rd == i_idex_rs.
- Otherwise FA = 00.
- FB uses the same rules with i_idex_rt.
- EX/MEM wins when both stages match (newest value).
- Code 11 is never driven, because the EX mux holds its previous value on 11.
- Register $0 is never forwarded.

Load-use detect (combinational):
- hz = i_idex_memread & (i_idex_rt != 0) & (i_idex_rt == i_ifid_rs | i_idex_rt == i_ifid_rt).

FSM states: RUN, STALL. A 3-bit down-counter scnt is used in STALL.
- RUN, hz=1, i_branch_taken=0:
  - Same cycle: o_pc_write=0, o_ifid_write=0, o_id_flush=1.
  - If LOAD_STALL_CYCLES > 1: go to STALL with scnt = LOAD_STALL_CYCLES-1.
  - Otherwise: stay in RUN.
- STALL:
  - Outputs: o_pc_write=0, o_ifid_write=0, o_id_flush=1.
  - scnt decrements each cycle; go to RUN in the cycle scnt==1.
  - hz is ignored while in STALL.
- i_branch_taken=1, any state:
  - Same cycle: o_if_flush=1, o_id_flush=1, ex_flush=1, o_pc_write=1, o_ifid_write=1.
  - Next state is RUN and scnt is cleared.
  - A taken branch overrides hz and aborts any stall in progress.
- Idle (no hazard, no branch): o_pc_write=1, o_ifid_write=1, all flushes 0.

Reset (i_rst=1 at a clock edge):
- state=RUN, scnt=0, counters=0.
- While i_rst is high, the control outputs are forced to the idle values above and FA=FB=00.
- Reset asserted mid-stall: the stall is abandoned; the first cycle after reset deasserts is RUN.

Optional Feature:
Macro: HAZARD_PERF_CNT_EN
- Defined:
  - o_stall_cnt increments by 1 on every cycle with o_pc_write=0.
  - o_flush_cnt increments by 1 on every cycle with i_branch_taken=1.
  - Both counters saturate at all-ones and do not wrap.
  - Both counters clear on i_rst.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Forward priority: exmem_rd=5 with regwrite=1, memwb_rd=5 with regwrite=1, idex_rs=5, idex_rt=5 -> FA=10, FB=10. Then clear exmem_regwrite -> FA=01, FB=01.
- $0 guard: exmem_rd=0 with regwrite=1, idex_rs=0 -> FA=00. Also drive rd=7 with regwrite=0, idex_rs=7 -> FA=00.
- Load-use, LOAD_STALL_CYCLES=1: idex_memread=1, idex_rt=8, ifid_rs=8 for one cycle -> exactly 1 cycle of pc_write=0, ifid_write=0, id_flush=1, then idle. Repeat with ifid_rt=8 -> same result.
- Load-use, LOAD_STALL_CYCLES=3: one hazard cycle -> 3 consecutive stall cycles. With HAZARD_PERF_CNT_EN, o_stall_cnt=3 afterwards.
- Branch during stall (LOAD_STALL_CYCLES=3): branch_taken=1 in the 2nd stall cycle -> that cycle gives if/id/ex_flush=1 and pc_write=1; the next cycle is idle. o_flush_cnt=1.
- Reset mid-stall: i_rst=1 for 1 cycle during STALL -> the next cycle shows pc_write=1 and counters=0.
